pipeline_host_ctrl: RTL
=======================

# pipeline_host_ctrl

Host-facing control and programming front end that sits directly upstream of the 5-stage `pipeline` core. It decodes a simple single-cycle host register bus into the core's run/step/PC-reset controls, the I-mem programming strobe, and a sequenced D-mem Port B write/readback handshake. It also exposes the core's PC and instruction debug outputs as readable registers.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset; one clock only.
- `host_wr`  in  1  register write strobe, one cycle per access.
- `host_rd`  in  1  register read strobe, one cycle per access.
- `host_addr`  in  4  register index.
- `host_wdata`  in  32  write data.
- `host_rdata`  out  32  read data, registered.
- `host_ack`  out  1  one-cycle acknowledge, registered.
- `run`  out  1  core free-run level.
- `step`  out  1  single-cycle step pulse.
- `pc_reset_pulse`  out  1  single-cycle software PC reset.
- `imem_prog_we`  out  1  I-mem write strobe.
- `imem_prog_addr`  out  9  I-mem write address.
- `imem_prog_wdata`  out  32  I-mem write data.
- `dmem_prog_en`, `dmem_prog_we`  out  1 each  D-mem Port B enable / write enable.
- `dmem_prog_addr`  out  8  D-mem Port B address.
- `dmem_prog_wdata`  out  64  D-mem Port B write data.
- `dmem_prog_rdata`  in  64  D-mem Port B read data; one-cycle BRAM latency.
- `pc_dbg`  in  9  core PC.
- `if_instr_dbg`  in  32  core instruction.

## Operation
Register map (`host_addr`):
- 0x0 CTRL: bit0 run (RW level); bit1 step (write 1 -> pulse); bit2 pc_reset (write 1 -> pulse); bit3 write 1 clears ERR. Reads return {run} in bit0, 0 elsewhere.
- 0x1 STATUS (RO): bit0 BUSY (D-mem FSM not IDLE), bit1 ERR (sticky), bit2 run.
- 0x2 IMEM_ADDR [8:0] RW. 0x3 IMEM_DATA: write loads `imem_prog_wdata` and fires `imem_prog_we`.
- 0x4 DMEM_ADDR [7:0] RW. 0x5/0x6 DMEM_WDATA_LO/HI RW.
- 0x7 DMEM_CMD (W): bit0 write-go, bit1 read-go.
- 0x8/0x9 DMEM_RDATA_LO/HI (RO), last captured readback.
- 0xA PC_DBG {23'b0,pc_dbg}; 0xB INSTR_DBG; 0xC-0xF read 0, writes ignored.

Rules:
- `host_wr` and `host_rd` both high: treated as write only.
- IMEM_DATA write while run=1: no strobe, ERR set.
- DMEM_CMD while BUSY, or with both bits set, or with neither: ignored; ERR set if BUSY or both bits set.
- D-mem FSM: IDLE -> WR (en=1, we=1, one cycle) -> IDLE; IDLE -> RD_ISSUE (en=1, we=0) -> RD_WAIT (en=0, capture `dmem_prog_rdata` into RDATA at end of cycle) -> IDLE.
- `dmem_prog_addr`/`dmem_prog_wdata` drive DMEM_ADDR/WDATA registers continuously.
- Step and pc_reset written together: both pulse in the same cycle.

## Timing
- Reset values: all outputs 0; all registers 0; FSM IDLE; ERR 0.
- `host_ack` and `host_rdata` valid in cycle T+1 for an access in cycle T; `host_rdata` is 0 in cycles without a read ack.
- CTRL write at T: `step`/`pc_reset_pulse` high in T+1 only; `run` updates at T+1.
- IMEM_DATA write at T: `imem_prog_we` high in T+1 only, with address and data stable in T+1.
- DMEM write-go at T: en/we high in T+1; BUSY readable 1 for accesses in T+1; IDLE at T+2.
- DMEM read-go at T: en high in T+1; data captured end of T+2; RDATA and BUSY=0 visible to a read issued at T+3.
- Reset mid-operation: FSM returns to IDLE, en/we low next cycle, no capture.

## Configuration
- `PIPE_HOST_AUTOINC_EN` defined: IMEM_ADDR increments after each successful I-mem strobe (511 wraps to 0). DMEM_ADDR increments after each completed D-mem write or read (255 wraps to 0).
- Not defined: both addresses hold until written by the host.

## Test plan
- Reset, then read 0x0-0xF -> all 0 except PC_DBG/INSTR_DBG mirroring their inputs; every `host_ack` arrives exactly one cycle after its strobe.
- Write CTRL=0x2, then CTRL=0x4 -> `step` single pulse, then `pc_reset_pulse` single pulse, each one cycle after its write; `run` stays 0.
- With run=0, IMEM_ADDR=0x1FF, IMEM_DATA=0xC0A00000 -> strobe at addr 0x1FF with that data. With AUTOINC, IMEM_ADDR reads 0x000 afterwards. With run=1, the same write gives no strobe and ERR=1.
- DMEM_ADDR=0x10, WDATA=0xDEADBEEF_01234567, CMD=1, then CMD=2 (with the model returning the stored word one cycle after en; DMEM_ADDR rewritten to 0x10 if AUTOINC) -> RDATA_HI/LO=0xDEADBEEF/0x01234567.
- CMD=2 immediately followed by CMD=1 -> second command ignored, ERR=1, exactly one en pulse; CTRL bit3 write -> ERR=0.
- Issue read-go, assert `reset` in the RD_WAIT cycle -> en/we low, RDATA stays 0, STATUS=0.

Source files
------------

// File: rtl/pipeline_host_ctrl.sv
// Host register front end for the 5-stage pipeline: run/step/PC-reset control,
// I-mem programming strobe and a sequenced D-mem Port B write/readback. Optional PIPE_HOST_AUTOINC_EN.
module pipeline_host_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_wr,
    input  logic        host_rd,
    input  logic [3:0]  host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_ack,
    output logic        run,
    output logic        step,
    output logic        pc_reset_pulse,
    output logic        imem_prog_we,
    output logic [8:0]  imem_prog_addr,
    output logic [31:0] imem_prog_wdata,
    output logic        dmem_prog_en,
    output logic        dmem_prog_we,
    output logic [7:0]  dmem_prog_addr,
    output logic [63:0] dmem_prog_wdata,
    input  logic [63:0] dmem_prog_rdata,
    input  logic [8:0]  pc_dbg,
    input  logic [31:0] if_instr_dbg
);
    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_ISSUE, S_RD_WAIT} dstate_t;
    dstate_t state_q, state_d;

    logic        ack_q, run_q, step_q, pcr_q, err_q, imem_we_q;
    logic [31:0] rdata_q, imem_wdata_q, rd_mux;
    logic [8:0]  imem_addr_q;
    logic [7:0]  dmem_addr_q;
    logic [63:0] dmem_wdata_q, dmem_rdata_q;
    logic        en_c, we_c;

    // A simultaneous write and read is a write only.
    logic wr, rd, busy, cmd_wr, go_w, go_r, cmd_err, imem_go, imem_err;
    assign wr       = host_wr;
    assign rd       = host_rd & ~host_wr;
    assign busy     = (state_q != S_IDLE);
    assign cmd_wr   = wr && (host_addr == 4'h7);
    assign go_w     = cmd_wr && !busy && (host_wdata[1:0] == 2'b01);
    assign go_r     = cmd_wr && !busy && (host_wdata[1:0] == 2'b10);
    assign cmd_err  = cmd_wr && (busy || (host_wdata[1:0] == 2'b11));
    assign imem_go  = wr && (host_addr == 4'h3) && !run_q;
    assign imem_err = wr && (host_addr == 4'h3) && run_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        en_c    = 1'b0;
        we_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go_w)      state_d = S_WR;
                else if (go_r) state_d = S_RD_ISSUE;
            end
            S_WR: begin
                en_c    = 1'b1;
                we_c    = 1'b1;
                state_d = S_IDLE;
            end
            S_RD_ISSUE: begin
                en_c    = 1'b1;
                state_d = S_RD_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'h0;
        case (host_addr)
            4'h0: rd_mux = {31'h0, run_q};
            4'h1: rd_mux = {29'h0, run_q, err_q, busy};
            4'h2: rd_mux = {23'h0, imem_addr_q};
            4'h4: rd_mux = {24'h0, dmem_addr_q};
            4'h5: rd_mux = dmem_wdata_q[31:0];
            4'h6: rd_mux = dmem_wdata_q[63:32];
            4'h8: rd_mux = dmem_rdata_q[31:0];
            4'h9: rd_mux = dmem_rdata_q[63:32];
            4'hA: rd_mux = {23'h0, pc_dbg};
            4'hB: rd_mux = if_instr_dbg;
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q        <= 1'b0;
            rdata_q      <= 32'h0;
            run_q        <= 1'b0;
            step_q       <= 1'b0;
            pcr_q        <= 1'b0;
            err_q        <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= 9'h0;
            imem_wdata_q <= 32'h0;
            dmem_addr_q  <= 8'h0;
            dmem_wdata_q <= 64'h0;
            dmem_rdata_q <= 64'h0;
        end else begin
            ack_q     <= host_wr | host_rd;
            rdata_q   <= rd ? rd_mux : 32'h0;
            step_q    <= 1'b0;
            pcr_q     <= 1'b0;
            imem_we_q <= imem_go;
            if (imem_go) imem_wdata_q <= host_wdata;
            if (state_q == S_RD_WAIT) dmem_rdata_q <= dmem_prog_rdata;
`ifdef PIPE_HOST_AUTOINC_EN
            // Increment after the strobe/access cycle; a host write below takes priority.
            if (imem_we_q) imem_addr_q <= imem_addr_q + 9'd1;
            if (state_q == S_WR || state_q == S_RD_WAIT) dmem_addr_q <= dmem_addr_q + 8'd1;
`endif
            if (imem_err || cmd_err) err_q <= 1'b1;
            if (wr) begin
                case (host_addr)
                    4'h0: begin
                        run_q  <= host_wdata[0];
                        step_q <= host_wdata[1];
                        pcr_q  <= host_wdata[2];
                        if (host_wdata[3]) err_q <= 1'b0;
                    end
                    4'h2: imem_addr_q <= host_wdata[8:0];
                    4'h4: dmem_addr_q <= host_wdata[7:0];
                    4'h5: dmem_wdata_q[31:0]  <= host_wdata;
                    4'h6: dmem_wdata_q[63:32] <= host_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign host_ack        = ack_q;
    assign host_rdata      = rdata_q;
    assign run             = run_q;
    assign step            = step_q;
    assign pc_reset_pulse  = pcr_q;
    assign imem_prog_we    = imem_we_q;
    assign imem_prog_addr  = imem_addr_q;
    assign imem_prog_wdata = imem_wdata_q;
    assign dmem_prog_en    = en_c;
    assign dmem_prog_we    = we_c;
    assign dmem_prog_addr  = dmem_addr_q;
    assign dmem_prog_wdata = dmem_wdata_q;
endmodule
